// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared FSM state type and one-hot helpers for the round-robin arbiter.
package rr_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r |= v[i] ? 32'(i) : 32'd0;
    return r;
  endfunction
  // Rotate left by one within the low n bits so bit n-1 wraps to bit 0.
  function automatic logic [31:0] rotl1(input logic [31:0] v, input int n);
    logic [31:0] m;
    logic [31:0] w;
    m = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    w = v & m;
    return ((w << 1) | (w >> (n - 1))) & m;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: circular priority picker returning the first req bit at or above ptr.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick
);
  localparam logic [2*N-1:0] ONE = 1;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_lo;
  // Upper copy of req catches requesters below ptr after the wrap.
  assign w_dbl = {req, req} & ~({{N{1'b0}}, ptr} - ONE);
  assign w_lo = w_dbl & (~w_dbl + ONE);
  assign pick = w_lo[N-1:0] | w_lo[2*N-1:N];
endmodule

// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: round-robin arbiter with ack/drop/timeout release and one-hot rotating pointer.
module rr_arbiter_ctrl
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           ack,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           timeout,
  output logic [N-1:0]   ptr
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  state_t r_state, w_state_n;
  logic [N-1:0] r_grant, w_grant_n, r_ptr, w_ptr_n, w_pick;
  logic [IDW-1:0] r_id, w_id_n;
  logic [HW-1:0] r_hold, w_hold_n;
  logic r_valid, w_valid_n, r_timeout, w_timeout_n, w_rel_norm, w_rel_to;
  rr_pick #(.N(N)) u_pick (.req(req), .ptr(r_ptr), .pick(w_pick));
  assign w_rel_norm = ack | ~|(req & r_grant);
  assign w_rel_to = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_id <= '0;
      r_timeout <= 1'b0;
      r_ptr <= N'(1);
      r_hold <= '0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_valid <= w_valid_n;
      r_id <= w_id_n;
      r_timeout <= w_timeout_n;
      r_ptr <= w_ptr_n;
      r_hold <= w_hold_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_valid_n = r_valid;
    w_id_n = r_id;
    w_ptr_n = r_ptr;
    w_hold_n = r_hold;
    w_timeout_n = 1'b0;
    if (r_state == IDLE) begin
      w_state_n = |w_pick ? BUSY : IDLE;
      w_grant_n = w_pick;
      w_valid_n = |w_pick;
      w_id_n = IDW'(onehot_to_idx(32'(w_pick)));
      w_hold_n = '0;
    end else if (w_rel_norm || w_rel_to) begin
      w_state_n = IDLE;
      w_grant_n = '0;
      w_valid_n = 1'b0;
      w_id_n = '0;
      w_ptr_n = N'(rotl1(32'(r_grant), N));
      w_hold_n = '0;
      w_timeout_n = w_rel_to & ~w_rel_norm;
    end else begin
      w_hold_n = (r_hold == HOLD_LAST) ? r_hold : r_hold + HW'(1);
    end
  end
  assign grant = r_grant;
  assign grant_valid = r_valid;
  assign grant_id = r_id;
  assign timeout = r_timeout;
  assign ptr = r_ptr;
endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// tb_rr_arbiter_ctrl: directed test-plan checks plus randomized traffic against an index-based reference model.
module tb_rr_arbiter_ctrl;
  localparam int N = 4;
  localparam int MH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack = 1'b0;
  logic [N-1:0] req = '1;
  logic [N-1:0] grant, ptr;
  logic grant_valid, timeout;
  logic [$clog2(N)-1:0] grant_id;
  int n_chk = 0;
  int n_fail = 0;
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_to = 1'b0;

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout), .ptr(ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: owner index (-1 = none), pointer index, cycles the owner has held the grant.
  always @(posedge clk) begin
    bit norm, tmo;
    m_to = 1'b0;
    if (rst) begin
      m_own = -1;
      m_ptr = 0;
      m_cnt = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++)
        if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      m_cnt = 0;
    end else begin
      norm = ack || !req[m_own];
      tmo = (MH != 0) && (m_cnt == MH - 1);
      if (norm || tmo) begin
        m_ptr = (m_own + 1) % N;
        m_to = tmo && !norm;
        m_own = -1;
      end else m_cnt++;
    end
  end

  always @(negedge clk) begin
    chk("model_grant", 32'(grant), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
    chk("model_valid", 32'(grant_valid), 32'(m_own >= 0));
    chk("model_id", 32'(grant_id), (m_own >= 0) ? 32'(m_own) : 32'd0);
    chk("model_timeout", 32'(timeout), 32'(m_to));
    chk("model_ptr", 32'(ptr), 32'd1 << m_ptr);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_ptr", 32'(ptr), 32'h1);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    tick();
    chk("first_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("rot_bubble", 32'(grant), 32'h0);
      tick();
      chk("rot_grant", 32'(grant), 32'(exp_g[i+1]));
      chk("rot_id", 32'(grant_id), 32'((i + 1) % N));
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = 4'b0100;
    tick();
    chk("pre_wrap_grant", 32'(grant), 32'h4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = 4'b0101;
    chk("wrap_ptr", 32'(ptr), 32'h8);
    tick();
    chk("wrap_grant", 32'(grant), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("skip_ptr", 32'(ptr), 32'h2);
    req = 4'b0100;
    tick();
    chk("skip_grant", 32'(grant), 32'h4);
    for (int i = 0; i < MH - 1; i++) begin
      tick();
      chk("hold_grant", 32'(grant), 32'h4);
    end
    tick();
    chk("to_grant", 32'(grant), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_ptr", 32'(ptr), 32'h8);
    tick();
    chk("to_regrant", 32'(grant), 32'h4);
    chk("to_pulse_end", 32'(timeout), 32'h0);
    req = 4'b0010;
    tick();
    tick();
    chk("stab_grant0", 32'(grant), 32'h2);
    for (int i = 0; i < MH - 1; i++) begin
      req = 4'($urandom) | 4'b0010;
      tick();
      chk("stab_grant", 32'(grant), 32'h2);
    end
    ack = 1'b1;
    req = 4'b0101;
    tick();
    ack = 1'b0;
    chk("simul_grant", 32'(grant), 32'h0);
    chk("simul_timeout", 32'(timeout), 32'h0);
    chk("simul_ptr", 32'(ptr), 32'h4);
    req = 4'b0100;
    tick();
    chk("mid_grant", 32'(grant), 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_ptr", 32'(ptr), 32'h1);
    chk("mid_rst_to", 32'(timeout), 32'h0);
    tick();
    chk("post_rst_grant", 32'(grant), 32'h4);
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      ack = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_ctrl.md
Name: rr_arbiter_ctrl

Overview:
- Round-robin arbiter controller. Shares one resource between N requesters.
- Holds a one-hot priority pointer and picks the next requester at or after it.
- Holds the grant until the owner acks, drops its request, or a hold timeout expires. Then rotates the pointer past the last owner.
- Sits between requester req/ack lines and the shared resource select.

Parameters:
N, 4, number of requesters (N >= 2).
MAX_HOLD, 8, maximum cycles a grant is held without ack; 0 disables the timeout.
IDW, $clog2(N), width of grant_id (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
req  input  N  request vector, bit i = requester i
ack  input  1  current owner signals completion (1-cycle pulse)
grant  output  N  one-hot grant, registered
grant_valid  output  1  OR of grant, registered
grant_id  output  IDW  binary index of granted requester, registered
timeout  output  1  1-cycle pulse: grant revoked by hold timeout
ptr  output  N  current one-hot priority pointer (debug/observe)

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - ptr=1 (bit0), state=IDLE, hold_cnt=0.
  - rst asserted mid-grant drops the grant at that edge; no timeout pulse.
- States: IDLE, BUSY.
- IDLE:
  - ack is ignored.
  - If req != 0: pick the first set req bit scanning circularly upward from ptr (ptr bit inclusive, wrap N-1 -> 0).
  - Next edge: register the grant and grant_id, set grant_valid=1, hold_cnt=0, go to BUSY.
  - Latency is one cycle from req visible to grant.
  - If req == 0: stay in IDLE with all outputs 0.
- BUSY:
  - grant is frozen; changes on other req bits have no effect.
  - hold_cnt increments each cycle. It saturates at MAX_HOLD-1 and is unused when MAX_HOLD=0.
- Release condition, evaluated in a BUSY cycle:
  - (a) ack=1, or
  - (b) the granted req bit = 0, or
  - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
- On release, at the next edge:
  - grant=0, grant_valid=0, state=IDLE.
  - ptr = rotate-left-by-1 of the current grant; bit N-1 wraps to bit0.
  - timeout=1 for that one cycle only if (c) held and neither (a) nor (b).
- Simultaneous (a)+(c) or (b)+(c): treated as a normal release, timeout=0.
- A grant therefore lasts at most MAX_HOLD cycles.
- Every release is followed by exactly one IDLE bubble cycle with grant=0 before the next grant. There are no back-to-back grants.
- Fairness: a continuously asserting requester waits at most N-1 other grants.
- ptr is always one-hot. It changes only on release or reset.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD) when MAX_HOLD > 1, else 1.
  - grant_id is the encoding of the grant.

Decomposition:
- Shared package (rr_arb_pkg):
  - state enum (IDLE=1'b0, BUSY=1'b1);
  - function onehot_to_idx;
  - function rotl1 for one-hot rotate.
- Sub-module rr_pick: combinational circular priority picker.
  - Inputs: req[N], ptr[N]. Output: one-hot pick[N].
  - Implemented via double-width masking.
  - Instantiated once.
- FSM, hold counter, pointer register and output registers live in rr_arbiter_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> grant=0000, grant_valid=0, ptr=0001, timeout=0. After rst=0: grant=0001 one cycle later.
- Rotation: req=1111 held, ack pulsed on the 2nd cycle of each grant -> grant sequence 0001,0010,0100,1000,0001. Exactly one grant=0000 cycle between grants; grant_id 0,1,2,3,0.
- Wrap/skip: ptr=1000 (after a 0100 release), req=0101 -> grant=0001, ptr becomes 0010 after its ack. Then req=0100 -> grant=0100.
- Timeout: MAX_HOLD=8, req=0100 held, no ack -> grant=0100 for exactly 8 cycles, then grant=0000 with timeout=1 for 1 cycle. ptr=1000; grant=0100 again after the bubble.
- Hold stability and simultaneous events: grant=0010, other req bits toggled -> grant unchanged. In one cycle, ack=1 with req[1]=0 and hold_cnt at MAX_HOLD-1 -> single release, timeout=0, ptr=0100.
- Reset mid-grant: grant=0100 in BUSY, rst=1 for 1 cycle -> next edge grant=0000, ptr=0001, no timeout pulse. With req=0100 still set, grant=0100 one cycle after rst deasserts.
